// File: rtl/ult_blink_ctrl.sv
// rtl/ult_blink_ctrl.sv - ultimate-skill indicator blink sequencer (IDLE -> FAST -> SLOW -> IDLE)
// Optional: define ULT_BLINK_RETRIGGER_EN to let START restart a running programme.
module ult_blink_ctrl #(
    parameter int CNT_W        = 27,
    parameter int FAST_CNT     = 12_500_000,
    parameter int SLOW_CNT     = 50_000_000,
    parameter int TOG_W        = 8,
    parameter int FAST_TOGGLES = 16,
    parameter int SLOW_TOGGLES = 4
) (
    input  logic       CLOCK,
    input  logic       RESET_N,
    input  logic       START,
    input  logic       ABORT,
    output logic       blink,
    output logic       busy,
    output logic       done,
    output logic [1:0] phase
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_FAST = 2'b01,
        ST_SLOW = 2'b10
    } state_t;

    localparam logic [CNT_W-1:0] FAST_LAST     = CNT_W'(FAST_CNT - 1);
    localparam logic [CNT_W-1:0] SLOW_LAST     = CNT_W'(SLOW_CNT - 1);
    localparam logic [TOG_W-1:0] FAST_TOG_LAST = TOG_W'(FAST_TOGGLES - 1);
    localparam logic [TOG_W-1:0] SLOW_TOG_LAST = TOG_W'(SLOW_TOGGLES - 1);

`ifdef ULT_BLINK_RETRIGGER_EN
    localparam bit RETRIG = 1'b1;
`else
    localparam bit RETRIG = 1'b0;
`endif

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [TOG_W-1:0] tog_q;
    logic             blink_q;
    logic             done_q;
    logic             tick;
    logic             last_tog;

    // Period and toggle limits follow whichever burst is currently active.
    always_comb begin
        tick     = 1'b0;
        last_tog = 1'b0;
        if (state_q == ST_FAST) begin
            tick     = (cnt_q == FAST_LAST);
            last_tog = (tog_q == FAST_TOG_LAST);
        end else if (state_q == ST_SLOW) begin
            tick     = (cnt_q == SLOW_LAST);
            last_tog = (tog_q == SLOW_TOG_LAST);
        end
    end

    always_ff @(posedge CLOCK) begin
        if (!RESET_N) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            tog_q   <= '0;
            blink_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (START && !ABORT) begin
                        state_q <= ST_FAST;
                        cnt_q   <= '0;
                        tog_q   <= '0;
                        blink_q <= 1'b1;
                    end
                end
                ST_FAST, ST_SLOW: begin
                    if (ABORT) begin
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                        tog_q   <= '0;
                        blink_q <= 1'b0;
                    end else if (RETRIG && START) begin
                        state_q <= ST_FAST;
                        cnt_q   <= '0;
                        tog_q   <= '0;
                        blink_q <= 1'b1;
                    end else if (tick) begin
                        cnt_q   <= '0;
                        blink_q <= ~blink_q;
                        if (last_tog) begin
                            tog_q <= '0;
                            if (state_q == ST_FAST) begin
                                state_q <= ST_SLOW;
                            end else begin
                                state_q <= ST_IDLE;
                                blink_q <= 1'b0;
                                done_q  <= 1'b1;
                            end
                        end else begin
                            tog_q <= tog_q + 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                    tog_q   <= '0;
                    blink_q <= 1'b0;
                end
            endcase
        end
    end

    assign blink = blink_q;
    assign busy  = (state_q != ST_IDLE);
    assign done  = done_q;
    assign phase = state_q;

endmodule

// File: tb/tb_ult_blink_ctrl.sv
// tb/tb_ult_blink_ctrl.sv - self-checking bench for ult_blink_ctrl (vectors, scenarios, random vs model)
module tb_ult_blink_ctrl;

    localparam int F  = 4;
    localparam int FT = 4;
    localparam int S  = 8;
    localparam int ST = 2;
    localparam int L  = F * FT + S * ST;

`ifdef ULT_BLINK_RETRIGGER_EN
    localparam bit RETRIG = 1'b1;
`else
    localparam bit RETRIG = 1'b0;
`endif

    logic       CLOCK = 1'b0;
    logic       RESET_N = 1'b0;
    logic       START = 1'b0;
    logic       ABORT = 1'b0;
    logic       blink;
    logic       busy;
    logic       done;
    logic [1:0] phase;

    ult_blink_ctrl #(
        .CNT_W(27), .FAST_CNT(F), .SLOW_CNT(S),
        .TOG_W(8), .FAST_TOGGLES(FT), .SLOW_TOGGLES(ST)
    ) dut (
        .CLOCK(CLOCK), .RESET_N(RESET_N), .START(START), .ABORT(ABORT),
        .blink(blink), .busy(busy), .done(done), .phase(phase)
    );

    always #5 CLOCK = ~CLOCK;

    int errors = 0;
    int checks = 0;

    // Reference: a programme is just "elapsed edges since start"; outputs follow from arithmetic on it.
    bit m_run  = 1'b0;
    int m_t    = 0;
    bit m_done = 1'b0;

    bit       hist_blink[64];
    bit       hist_busy[64];
    bit [1:0] hist_phase[64];

    typedef struct {
        bit       rst_n;
        bit       start;
        bit       abort;
        bit       blink;
        bit       busy;
        bit       done;
        bit [1:0] phase;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    task automatic model_edge(input bit rst_n, input bit st, input bit ab);
        m_done = 1'b0;
        if (!rst_n) begin
            m_run = 1'b0;
        end else if (m_run) begin
            if (ab) begin
                m_run = 1'b0;
            end else if (RETRIG && st) begin
                m_t = 0;
            end else begin
                m_t++;
                if (m_t == L) begin
                    m_run  = 1'b0;
                    m_done = 1'b1;
                end
            end
        end else if (st && !ab) begin
            m_run = 1'b1;
            m_t   = 0;
        end
    endtask

    function automatic int exp_blink();
        if (!m_run) return 0;
        if (m_t < F * FT) return ((m_t / F) % 2 == 0) ? 1 : 0;
        return ((FT + (m_t - F * FT) / S) % 2 == 0) ? 1 : 0;
    endfunction

    function automatic int exp_phase();
        if (!m_run) return 0;
        return (m_t < F * FT) ? 1 : 2;
    endfunction

    task automatic step(input bit rst_n, input bit st, input bit ab);
        RESET_N = rst_n;
        START   = st;
        ABORT   = ab;
        @(posedge CLOCK);
        #1;
        model_edge(rst_n, st, ab);
        chk("model_blink", int'(blink), exp_blink());
        chk("model_busy", int'(busy), int'(m_run));
        chk("model_done", int'(done), int'(m_done));
        chk("model_phase", int'(phase), exp_phase());
    endtask

    task automatic scenario(input int n, input bit hold, input int pulse_at, input int abort_at,
                            input bit abort_with_start, output int done_at, output int n_done);
        bit st;
        bit ab;
        done_at = -1;
        n_done  = 0;
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        for (int e = 0; e < n; e++) begin
            st = (e == 0) || hold || (e == pulse_at) || (abort_with_start && e == abort_at);
            ab = (e == abort_at);
            step(1'b1, st, ab);
            hist_blink[e] = blink;
            hist_busy[e]  = busy;
            hist_phase[e] = phase;
            if (done) begin
                n_done++;
                if (done_at < 0) done_at = e;
            end
        end
    endtask

    initial begin
        int done_at;
        int n_done;
        int rnd_done;

        vecs[0]  = '{0, 0, 0, 0, 0, 0, 2'b00};
        vecs[1]  = '{1, 1, 1, 0, 0, 0, 2'b00};
        vecs[2]  = '{1, 1, 0, 1, 1, 0, 2'b01};
        vecs[3]  = '{1, 0, 0, 1, 1, 0, 2'b01};
        vecs[4]  = '{1, 0, 0, 1, 1, 0, 2'b01};
        vecs[5]  = '{1, 0, 1, 0, 0, 0, 2'b00};
        vecs[6]  = '{1, 1, 0, 1, 1, 0, 2'b01};
        vecs[7]  = '{1, 0, 0, 1, 1, 0, 2'b01};
        vecs[8]  = '{0, 0, 0, 0, 0, 0, 2'b00};
        vecs[9]  = '{0, 1, 0, 0, 0, 0, 2'b00};
        vecs[10] = '{0, 0, 0, 0, 0, 0, 2'b00};
        vecs[11] = '{1, 0, 0, 0, 0, 0, 2'b00};

        for (int i = 0; i < 12; i++) begin
            step(vecs[i].rst_n, vecs[i].start, vecs[i].abort);
            chk($sformatf("vec%0d_blink", i), int'(blink), int'(vecs[i].blink));
            chk($sformatf("vec%0d_busy", i), int'(busy), int'(vecs[i].busy));
            chk($sformatf("vec%0d_done", i), int'(done), int'(vecs[i].done));
            chk($sformatf("vec%0d_phase", i), int'(phase), int'(vecs[i].phase));
        end

        // Full programme
        scenario(40, 1'b0, -1, -1, 1'b0, done_at, n_done);
        chk("full_done_edge", done_at, 32);
        chk("full_done_count", n_done, 1);
        chk("full_blink0", int'(hist_blink[0]), 1);
        chk("full_blink3", int'(hist_blink[3]), 1);
        chk("full_blink4", int'(hist_blink[4]), 0);
        chk("full_blink8", int'(hist_blink[8]), 1);
        chk("full_blink12", int'(hist_blink[12]), 0);
        chk("full_blink16", int'(hist_blink[16]), 1);
        chk("full_phase15", int'(hist_phase[15]), 1);
        chk("full_phase16", int'(hist_phase[16]), 2);
        chk("full_blink24", int'(hist_blink[24]), 0);
        chk("full_busy31", int'(hist_busy[31]), 1);
        chk("full_busy32", int'(hist_busy[32]), 0);
        chk("full_blink32", int'(hist_blink[32]), 0);

        // ABORT mid-FAST
        scenario(40, 1'b0, -1, 10, 1'b0, done_at, n_done);
        chk("abort_done_count", n_done, 0);
        chk("abort_phase10", int'(hist_phase[10]), 0);
        chk("abort_blink10", int'(hist_blink[10]), 0);
        chk("abort_blink20", int'(hist_blink[20]), 0);

        // START+ABORT together mid-SLOW
        scenario(40, 1'b0, -1, 20, 1'b1, done_at, n_done);
        chk("both_slow_phase19", int'(hist_phase[19]), 2);
        chk("both_slow_busy20", int'(hist_busy[20]), 0);
        chk("both_slow_done_count", n_done, 0);

        // START pulse while busy
        scenario(44, 1'b0, 6, -1, 1'b0, done_at, n_done);
        chk("retrig_done_edge", done_at, RETRIG ? 38 : 32);
        chk("retrig_blink6", int'(hist_blink[6]), RETRIG ? 1 : 0);
        chk("retrig_done_count", n_done, 1);

        // START held high
        scenario(40, 1'b1, -1, -1, 1'b0, done_at, n_done);
        if (RETRIG) begin
            chk("hold_done_count", n_done, 0);
            chk("hold_blink33", int'(hist_blink[33]), 1);
        end else begin
            chk("hold_done_edge", done_at, 32);
            chk("hold_done_count", n_done, 1);
            chk("hold_blink33", int'(hist_blink[33]), 1);
            chk("hold_busy33", int'(hist_busy[33]), 1);
            chk("hold_phase33", int'(hist_phase[33]), 1);
        end

        // Random traffic against the reference model
        rnd_done = 0;
        step(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4000; i++) begin
            step($urandom_range(0, 99) != 0, $urandom_range(0, 9) == 0, $urandom_range(0, 79) == 0);
            if (done) rnd_done++;
        end
        chk("random_saw_completion", int'(rnd_done > 0), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
